// File: rtl/sine_ref_gen.sv
// sine_ref_gen: multi-channel quarter-wave sine reference for the SSPWM modulator.
// Optional build macro SINE_OFFSET_EN biases each magnitude by PEAK (range 0..2*PEAK).
module sine_ref_gen #(
    parameter int    PHASE_W  = 16,
    parameter int    ADDR_W   = 7,
    parameter int    AMP_W    = 13,
    parameter int    PEAK     = 5000,
    parameter int    MI_W     = 10,
    parameter int    CH       = 3,
    parameter string LUT_FILE = "sine_q.hex"
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    tick,
    input  logic                    sync,
    input  logic [PHASE_W-1:0]      phase_inc,
    input  logic [MI_W:0]           mod_idx,
    output logic [CH*(AMP_W+1)-1:0] sine_mag,
    output logic [CH-1:0]           sine_neg,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    overrun
);

    localparam int N  = 1 << ADDR_W;
    localparam int OW = AMP_W + 1;
    localparam int PW = AMP_W + MI_W + 1;
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [PHASE_W-1:0] OFF = PHASE_W'((64'd1 << PHASE_W) / 64'(CH));

    if (PHASE_W < ADDR_W + 2 || CH < 1 || CH > 8 || LUT_FILE == "") begin : g_bad_cfg
        $error("sine_ref_gen: unsupported configuration");
    end

    // Table equals the LUT_FILE image, built at elaboration from a Q30 Taylor series.
    function automatic logic [AMP_W-1:0] sine_val(input int i);
        longint x, term, sum, v;
        x    = (longint'(1686629713) * longint'(i)) / longint'(N);
        term = x;
        sum  = x;
        for (int k = 1; k <= 8; k++) begin
            term = (term * x) >>> 30;
            term = (term * x) >>> 30;
            term = -term / longint'(2 * k * (2 * k + 1));
            sum  = sum + term;
        end
        v = (longint'(PEAK) * sum + (longint'(1) <<< 29)) >>> 30;
        return AMP_W'(v);
    endfunction

    typedef enum logic [2:0] {IDLE, LOOKUP, SCALE, STORE, DONE} state_t;

    state_t             state, state_nx;
    logic [PHASE_W-1:0] acc, base, b, p;
    logic               sync_pend, accept, publish;
    logic [MI_W:0]      mi;
    logic [CW-1:0]      ch;
    logic [ADDR_W+1:0]  ptop;
    logic [ADDR_W:0]    a, addr;
    logic               addr_neg;
    logic [AMP_W-1:0]   lut, m;
    logic [PW-1:0]      prod;
    logic [AMP_W-1:0]   rom [N+1];
    logic [AMP_W-1:0]   slot_mag [CH];
    logic [CH-1:0]      slot_neg;
    logic [CH*OW-1:0]   frame;

    for (genvar g = 0; g <= N; g++) begin : g_rom
        assign rom[g] = sine_val(g);
    end

    assign accept = tick & en & (state == IDLE);
    assign b      = (sync | sync_pend) ? '0 : acc;
    assign busy   = (state != IDLE);

    assign p    = base + PHASE_W'(64'(ch) * 64'(OFF));
    assign ptop = (ADDR_W+2)'(p >> (PHASE_W - ADDR_W - 2));
    assign a    = ptop[ADDR_W] ? (ADDR_W+1)'(N) - {1'b0, ptop[ADDR_W-1:0]}
                               : {1'b0, ptop[ADDR_W-1:0]};
    assign prod = PW'(lut) * PW'(mi);
    assign m    = AMP_W'(prod >> MI_W);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (tick & en) state_nx = LOOKUP;
            LOOKUP:  state_nx = SCALE;
            SCALE:   state_nx = STORE;
            STORE:   state_nx = (ch == CW'(CH - 1)) ? DONE : LOOKUP;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        frame = '0;
        for (int i = 0; i < CH; i++) begin
`ifdef SINE_OFFSET_EN
            frame[i*OW +: OW] = slot_neg[i] ? OW'(PEAK) - OW'(slot_mag[i])
                                            : OW'(PEAK) + OW'(slot_mag[i]);
`else
            frame[i*OW +: OW] = OW'(slot_mag[i]);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            base      <= '0;
            sync_pend <= 1'b0;
            mi        <= '0;
            ch        <= '0;
            addr      <= '0;
            addr_neg  <= 1'b0;
            lut       <= '0;
            slot_neg  <= '0;
            publish   <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            sine_mag  <= '0;
            sine_neg  <= '0;
            for (int i = 0; i < CH; i++) slot_mag[i] <= '0;
        end else begin
            state     <= state_nx;
            overrun   <= tick & en & (state != IDLE);
            lut       <= rom[addr];
            // Frame leaves through the output flops one cycle after DONE.
            publish   <= (state == DONE);
            out_valid <= publish;
            if (publish) begin
                sine_mag <= frame;
                sine_neg <= slot_neg;
            end
            if (accept) begin
                base      <= b;
                acc       <= b + phase_inc;
                mi        <= mod_idx[MI_W] ? (MI_W+1)'(1 << MI_W) : mod_idx;
                sync_pend <= 1'b0;
                ch        <= '0;
            end else if (sync) begin
                sync_pend <= 1'b1;
            end
            if (state == LOOKUP) begin
                addr     <= a;
                addr_neg <= ptop[ADDR_W+1];
            end
            if (state == STORE) begin
                ch <= ch + 1'b1;
                for (int i = 0; i < CH; i++) begin
                    if (ch == CW'(i)) begin
                        slot_mag[i] <= m;
                        slot_neg[i] <= addr_neg & (m != '0);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sine_ref_gen.sv
// tb_sine_ref_gen: directed checks of frame values, latency, overrun, sync and reset.
// Expected magnitudes are hand-computed from round(5000*sin(pi/2*a/128)).
module tb_sine_ref_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        tick = 1'b0;
    logic        sync = 1'b0;
    logic [15:0] phase_inc = 16'h0;
    logic [10:0] mod_idx = 11'd1024;
    logic [41:0] sine_mag;
    logic [2:0]  sine_neg;
    logic        out_valid;
    logic        busy;
    logic        overrun;

    int n_pass = 0;
    int n_total = 0;
    int lat;

`ifdef SINE_OFFSET_EN
    localparam int OFS = 5000;
`else
    localparam int OFS = 0;
`endif

    sine_ref_gen dut (
        .clk(clk), .rst(rst), .en(en), .tick(tick), .sync(sync),
        .phase_inc(phase_inc), .mod_idx(mod_idx),
        .sine_mag(sine_mag), .sine_neg(sine_neg),
        .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] em(input int m, input bit neg);
        if (OFS == 0) return 14'(m);
        return neg ? 14'(OFS - m) : 14'(OFS + m);
    endfunction

    task automatic fire(input logic s, input logic [10:0] mi, input logic [15:0] inc);
        @(negedge clk);
        sync = s;
        mod_idx = mi;
        phase_inc = inc;
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        sync = 1'b0;
    endtask

    task automatic wait_frame(output int l);
        l = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                l = i;
                break;
            end
        end
        n_total++;
        if (l < 0) $display("FAIL frame_timeout got none want out_valid within 40");
        else n_pass++;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({sine_mag, sine_neg, out_valid, overrun} !== '0)
            $display("FAIL reset_outputs got %h want 0", {sine_mag, sine_neg, out_valid, overrun});
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        fire(1'b0, 11'd1024, 16'h4000);
        wait_frame(lat);
        n_total++;
        if (lat !== 11) $display("FAIL latency got %0d want 11", lat);
        else n_pass++;
        n_total++;
        if (sine_mag[13:0] !== em(0, 0) || sine_neg[0] !== 1'b0)
            $display("FAIL f0_ch0 got %0d/%b want %0d/0", sine_mag[13:0], sine_neg[0], em(0, 0));
        else n_pass++;
        n_total++;
        if (sine_mag[27:14] !== em(4350, 0) || sine_neg[1] !== 1'b0)
            $display("FAIL f0_ch1 got %0d/%b want %0d/0", sine_mag[27:14], sine_neg[1], em(4350, 0));
        else n_pass++;
        n_total++;
        if (sine_mag[41:28] !== em(4320, 1) || sine_neg[2] !== 1'b1)
            $display("FAIL f0_ch2 got %0d/%b want %0d/1", sine_mag[41:28], sine_neg[2], em(4320, 1));
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL valid_pulse got v=%b b=%b want v=0 b=0", out_valid, busy);
        else n_pass++;
        fire(1'b0, 11'd1024, 16'h4000);
        wait_frame(lat);
        n_total++;
        if (sine_mag[13:0] !== em(5000, 0) || sine_neg[0] !== 1'b0)
            $display("FAIL f1_ch0 got %0d/%b want %0d/0", sine_mag[13:0], sine_neg[0], em(5000, 0));
        else n_pass++;
    endtask

    task automatic test_mod_idx;
        fire(1'b1, 11'd1024, 16'h4000);
        wait_frame(lat);
        fire(1'b0, 11'd512, 16'h4000);
        wait_frame(lat);
        n_total++;
        if (sine_mag[13:0] !== em(2500, 0))
            $display("FAIL mi_half got %0d want %0d", sine_mag[13:0], em(2500, 0));
        else n_pass++;
        fire(1'b1, 11'd2047, 16'h4000);
        wait_frame(lat);
        fire(1'b0, 11'd2047, 16'h4000);
        wait_frame(lat);
        n_total++;
        if (sine_mag[13:0] !== em(5000, 0))
            $display("FAIL mi_clamp got %0d want %0d", sine_mag[13:0], em(5000, 0));
        else n_pass++;
    endtask

    task automatic test_wrap;
        fire(1'b1, 11'd1024, 16'hC000);
        wait_frame(lat);
        n_total++;
        if (sine_mag[13:0] !== em(0, 0) || sine_neg[0] !== 1'b0)
            $display("FAIL wrap_p0 got %0d/%b want %0d/0", sine_mag[13:0], sine_neg[0], em(0, 0));
        else n_pass++;
        fire(1'b0, 11'd1024, 16'hC000);
        wait_frame(lat);
        n_total++;
        if (sine_mag[13:0] !== em(5000, 1) || sine_neg[0] !== 1'b1)
            $display("FAIL wrap_pC000 got %0d/%b want %0d/1", sine_mag[13:0], sine_neg[0], em(5000, 1));
        else n_pass++;
        fire(1'b0, 11'd1024, 16'hC000);
        wait_frame(lat);
        n_total++;
        if (sine_mag[13:0] !== em(0, 0) || sine_neg[0] !== 1'b0)
            $display("FAIL wrap_p8000 got %0d/%b want %0d/0", sine_mag[13:0], sine_neg[0], em(0, 0));
        else n_pass++;
    endtask

    task automatic test_overrun;
        fire(1'b1, 11'd1024, 16'h2000);
        wait_frame(lat);
        fire(1'b0, 11'd1024, 16'h2000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        n_total++;
        if (overrun !== 1'b1) $display("FAIL overrun_set got %b want 1", overrun);
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (overrun !== 1'b0) $display("FAIL overrun_pulse got %b want 0", overrun);
        else n_pass++;
        wait_frame(lat);
        n_total++;
        if (sine_mag[13:0] !== em(3536, 0))
            $display("FAIL p2000 got %0d want %0d", sine_mag[13:0], em(3536, 0));
        else n_pass++;
        fire(1'b0, 11'd1024, 16'h2000);
        wait_frame(lat);
        n_total++;
        if (sine_mag[13:0] !== em(5000, 0))
            $display("FAIL acc_once got %0d want %0d", sine_mag[13:0], em(5000, 0));
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        fire(1'b1, 11'd1024, 16'h4000);
        repeat (9) @(posedge clk);
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        n_total++;
        if (overrun !== 1'b1 || busy !== 1'b0)
            $display("FAIL done_tick got o=%b b=%b want o=1 b=0", overrun, busy);
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (out_valid !== 1'b1 || sine_mag[13:0] !== em(0, 0))
            $display("FAIL done_frame got v=%b m=%0d want v=1 m=%0d", out_valid, sine_mag[13:0], em(0, 0));
        else n_pass++;
        @(negedge clk);
        en = 1'b0;
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        n_total++;
        if (busy !== 1'b0 || overrun !== 1'b0)
            $display("FAIL en_low got b=%b o=%b want b=0 o=0", busy, overrun);
        else n_pass++;
        en = 1'b1;
        fire(1'b0, 11'd1024, 16'h4000);
        wait_frame(lat);
        n_total++;
        if (sine_mag[13:0] !== em(5000, 0))
            $display("FAIL acc_kept got %0d want %0d", sine_mag[13:0], em(5000, 0));
        else n_pass++;
    endtask

    task automatic test_sync;
        fire(1'b0, 11'd1024, 16'h4000);
        @(negedge clk);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        wait_frame(lat);
        fire(1'b0, 11'd1024, 16'h4000);
        wait_frame(lat);
        n_total++;
        if (sine_mag[13:0] !== em(0, 0) || sine_neg[0] !== 1'b0)
            $display("FAIL sync_pend got %0d/%b want %0d/0", sine_mag[13:0], sine_neg[0], em(0, 0));
        else n_pass++;
        fire(1'b0, 11'd1024, 16'h4000);
        wait_frame(lat);
        n_total++;
        if (sine_mag[13:0] !== em(5000, 0))
            $display("FAIL sync_acc got %0d want %0d", sine_mag[13:0], em(5000, 0));
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int seen;
        fire(1'b0, 11'd1024, 16'h4000);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_total++;
        if ({sine_mag, sine_neg, overrun, busy} !== '0)
            $display("FAIL rst_mid got %h want 0", {sine_mag, sine_neg, overrun, busy});
        else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        n_total++;
        if (seen !== 0) $display("FAIL rst_abort got %0d valids want 0", seen);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mod_idx();
        test_wrap();
        test_overrun();
        test_back_to_back();
        test_sync();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
